ram_arbiter: RTL and testbench

Round-robin arbiter and command sequencer sharing the single-port 256x8 RAM between `NREQ` requesters, e.g. the SPI slave path and a local debug/config port. Each granted request runs as an atomic RAM transaction: two 10-bit command frames on the RAM `din`/`rx_valid` inputs, then, for reads, capture of `dout` on `tx_valid`. Frames use the RAM command encoding: `din[9:8]` 00 = write address, 01 = write data, 10 = read address, 11 = read data; `din[7:0]` is the payload. The block sits between the requesters and the RAM.

---
 rtl/ram_arbiter_if.sv | 31 +++
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of requester-side and RAM-side signals of ram_arbiter.
//   Requester side: req, req_wr, req_addr, req_wdata (to arbiter),
//                   gnt, done, rdata, err (from arbiter).
//   RAM side:       ram_din, ram_rx_valid (to RAM), ram_dout, ram_tx_valid (from RAM).
// slave modport is the arbiter's view; master modport is the environment's view.
interface ram_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_wr;
  logic [8*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [7:0]        rdata;
  logic              err;
  logic [9:0]        ram_din;
  logic              ram_rx_valid;
  logic [7:0]        ram_dout;
  logic              ram_tx_valid;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, ram_dout, ram_tx_valid,
    output gnt, done, rdata, err, ram_din, ram_rx_valid
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, ram_dout, ram_tx_valid,
    input  gnt, done, rdata, err, ram_din, ram_rx_valid
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and command sequencer in front of a
// single-port 256x8 RAM that takes 10-bit command frames.
// Each grant runs one atomic transaction: address frame, data frame, then
// for reads a bounded wait for ram_tx_valid.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ram_arbiter_if.slave (requests/grants/completions and RAM frames)
// All outputs are registered and reset to zero.
module ram_arbiter #(
  parameter int NREQ       = 2,
  parameter int RD_TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           rst,
  ram_arbiter_if.slave   bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);
  localparam logic [PTR_W:0]   NREQ_W = (PTR_W + 1)'(NREQ);
  localparam logic [3:0]       TMO = 4'(RD_TIMEOUT);
  localparam logic [NREQ-1:0]  ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RWAIT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [9:0]         din_q, din_d;
  logic               rxv_q, rxv_d;

  // Request vector rotated so bit 0 is the requester at the pointer.
  logic [2*NREQ-1:0]  rot;
  logic               found;
  logic [PTR_W-1:0]   off;
  logic [PTR_W:0]     win_sum;
  logic [PTR_W-1:0]   win;
  logic [3:0]         cnt_inc;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    din_d   = din_q;
    rxv_d   = 1'b0;
    rot     = {bus.req, bus.req} >> ptr_q;
    found   = 1'b0;
    off     = '0;
    win_sum = '0;
    win     = '0;
    cnt_inc = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        for (int k = 0; k < NREQ; k++) begin
          if (!found && rot[k]) begin
            found = 1'b1;
            off   = PTR_W'(k);
          end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, off};
        win     = (win_sum >= NREQ_W) ? PTR_W'(win_sum - NREQ_W) : PTR_W'(win_sum);
        if (found) begin
          for (int j = 0; j < NREQ; j++) begin
            if (win == PTR_W'(j)) begin
              wr_d    = bus.req_wr[j];
              addr_d  = bus.req_addr[8*j +: 8];
              wdata_d = bus.req_wdata[8*j +: 8];
            end
          end
          owner_d = win;
          gnt_d   = ONE << win;
          ptr_d   = (win == LAST) ? '0 : win + 1'b1;
          din_d   = {(wr_d ? 2'b00 : 2'b10), addr_d};
          rxv_d   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        din_d   = {(wr_q ? 2'b01 : 2'b11), (wr_q ? wdata_q : 8'h00)};
        rxv_d   = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        if (wr_q) begin
          done_d  = ONE << owner_q;
          state_d = IDLE;
        end else begin
          cnt_d   = 4'd0;
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        if (bus.ram_tx_valid) begin
          rdata_d = bus.ram_dout;
          done_d  = ONE << owner_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            rdata_d = 8'h00;
            done_d  = ONE << owner_q;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and all visible outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      din_q   <= '0;
      rxv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      din_q   <= din_d;
      rxv_q   <= rxv_d;
    end
  end

  // Latched operands of the granted request; only read after a grant.
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    owner_q <= owner_d;
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.rdata        = rdata_q;
  assign bus.err          = err_q;
  assign bus.ram_din      = din_q;
  assign bus.ram_rx_valid = rxv_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed plus randomized bench for ram_arbiter with a
// behavioural RAM and a transaction-level reference model.
module tb_ram_arbiter;
  localparam int NREQ       = 2;
  localparam int RD_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_arbiter_if #(.NREQ(NREQ)) bus ();

  ram_arbiter #(.NREQ(NREQ), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Requester-side stimulus, packed onto the bus.
  logic [NREQ-1:0] t_req  = '0;
  logic [NREQ-1:0] t_wr   = '0;
  logic [7:0]      t_addr  [NREQ];
  logic [7:0]      t_wdata [NREQ];

  always_comb begin
    bus.req    = t_req;
    bus.req_wr = t_wr;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[8*i +: 8]  = t_addr[i];
      bus.req_wdata[8*i +: 8] = t_wdata[i];
    end
  end

  // Behavioural RAM: decodes frames, answers a read-data frame one cycle later.
  logic [7:0] ram_mem [256] = '{default: 8'h00};
  logic [7:0] ram_ad = 8'h00;
  logic [7:0] ram_dout_r = 8'h00;
  logic       ram_tv_r = 1'b0;
  logic       ram_stuck = 1'b0;
  logic       spur = 1'b0;

  always @(posedge clk) begin
    ram_tv_r <= 1'b0;
    if (bus.ram_rx_valid) begin
      case (bus.ram_din[9:8])
        2'b00, 2'b10: ram_ad <= bus.ram_din[7:0];
        2'b01:        ram_mem[ram_ad] <= bus.ram_din[7:0];
        default: if (!ram_stuck) begin
          ram_dout_r <= ram_mem[ram_ad];
          ram_tv_r   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ram_dout     = ram_dout_r;
  assign bus.ram_tx_valid = ram_tv_r | spur;

  // Reference model state.
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int         mptr   = 0;
  logic [7:0] mrdata = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: the model picks the round-robin winner and predicts every
  // cycle of frames, done pulse, rdata and err.
  task automatic do_txn(input bit hold, input bit stuck);
    int              w;
    logic            ew;
    logic [7:0]      ea, ed;
    logic [NREQ-1:0] oh;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (mptr + k) % NREQ;
      if (w < 0 && t_req[j]) w = j;
    end
    if (w < 0) return;
    ew = t_wr[w];
    ea = t_addr[w];
    ed = t_wdata[w];
    oh = NREQ'(1) << w;
    ram_stuck = stuck;

    @(posedge clk); #1;
    chk("gnt",     32'(bus.gnt), 32'(oh));
    chk("f1_vld",  32'(bus.ram_rx_valid), 32'd1);
    chk("f1_din",  32'(bus.ram_din), 32'({(ew ? 2'b00 : 2'b10), ea}));
    chk("f1_done", 32'(bus.done), 32'd0);
    mptr = (w + 1) % NREQ;
    if (!hold) t_req[w] = 1'b0;

    @(posedge clk); #1;
    chk("f2_gnt", 32'(bus.gnt), 32'd0);
    chk("f2_vld", 32'(bus.ram_rx_valid), 32'd1);
    chk("f2_din", 32'(bus.ram_din), 32'({(ew ? 2'b01 : 2'b11), (ew ? ed : 8'h00)}));

    @(posedge clk); #1;
    chk("d_vld", 32'(bus.ram_rx_valid), 32'd0);
    if (ew) begin
      ref_mem[ea] = ed;
      chk("wr_done",  32'(bus.done), 32'(oh));
      chk("wr_err",   32'(bus.err), 32'd0);
      chk("wr_rdata", 32'(bus.rdata), 32'(mrdata));
    end else begin
      chk("rd_early", 32'(bus.done), 32'd0);
      if (!stuck) begin
        @(posedge clk); #1;
        mrdata = ref_mem[ea];
        chk("rd_done",  32'(bus.done), 32'(oh));
        chk("rd_err",   32'(bus.err), 32'd0);
        chk("rd_rdata", 32'(bus.rdata), 32'(mrdata));
      end else begin
        for (int c = 1; c < RD_TIMEOUT; c++) begin
          @(posedge clk); #1;
          chk("to_wait", 32'(bus.done), 32'd0);
        end
        @(posedge clk); #1;
        mrdata = 8'h00;
        chk("to_done",  32'(bus.done), 32'(oh));
        chk("to_err",   32'(bus.err), 32'd1);
        chk("to_rdata", 32'(bus.rdata), 32'd0);
      end
    end
    ram_stuck = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(bus.gnt), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    chk({tag, "_err"},   32'(bus.err), 32'd0);
    chk({tag, "_din"},   32'(bus.ram_din), 32'd0);
    chk({tag, "_vld"},   32'(bus.ram_rx_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      t_addr[i]  = 8'h00;
      t_wdata[i] = 8'h00;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;

    // Write: requester 0, addr 3C, data A5
    t_wr[0] = 1'b1; t_addr[0] = 8'h3C; t_wdata[0] = 8'hA5; t_req = 2'b01;
    do_txn(1'b0, 1'b0);

    // Read-back: requester 1 reads addr 3C
    t_wr[1] = 1'b0; t_addr[1] = 8'h3C; t_req = 2'b10;
    do_txn(1'b0, 1'b0);

    // Spurious ram_tx_valid in IDLE must be ignored
    spur = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("spur_done",  32'(bus.done), 32'd0);
      chk("spur_rdata", 32'(bus.rdata), 32'(mrdata));
    end
    spur = 1'b0;

    // Asynchronous reset mid-cycle while a frame is on the bus
    t_wr[0] = 1'b1; t_addr[0] = 8'h10; t_wdata[0] = 8'h55; t_req = 2'b01;
    @(posedge clk); #1;
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h1);
    t_req = '0;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    mrdata = 8'h00;

    // Contention: both held high, grants alternate starting at 0
    t_wr[0] = 1'b1; t_addr[0] = 8'h20; t_wdata[0] = 8'h11;
    t_wr[1] = 1'b0; t_addr[1] = 8'h20;
    t_req = 2'b11;
    repeat (4) do_txn(1'b1, 1'b0);
    t_req = '0;

    // Timeout read
    t_wr[0] = 1'b0; t_addr[0] = 8'h20; t_req = 2'b01;
    do_txn(1'b0, 1'b1);

    // Abort a read in DATA
    t_wr[0] = 1'b0; t_addr[0] = 8'h3C; t_req = 2'b01;
    @(posedge clk); #1;
    chk("ab_gnt", 32'(bus.gnt), 32'h1);
    t_req = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("ab_vld",  32'(bus.ram_rx_valid), 32'd0);
    chk("ab_done", 32'(bus.done), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("ab_hold_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    mrdata = 8'h00;
    t_wr[1] = 1'b1; t_addr[1] = 8'h3D; t_wdata[1] = 8'h7E; t_req = 2'b10;
    do_txn(1'b0, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!t_req[i] && ($urandom_range(0, 1) == 1)) begin
          t_wr[i]    = 1'($urandom_range(0, 1));
          t_addr[i]  = 8'h40 + 8'($urandom_range(0, 3));
          t_wdata[i] = 8'($urandom);
          t_req[i]   = 1'b1;
        end
      end
      if (t_req == '0) begin
        t_wr[0] = 1'b0; t_addr[0] = 8'h41; t_req[0] = 1'b1;
      end
      do_txn(1'b0, ($urandom_range(0, 7) == 0));
    end
    t_req = '0;

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
